// File: rtl/wb_host_arbiter_if.sv
`default_nettype none
// ============================================================================
// wb_host_arbiter_if : requester-side and Wishbone-side signals of the
//                      two-requester Wishbone host arbiter.
// Revision: 1.0
// ============================================================================
interface wb_host_arbiter_if #(
  parameter int ADR_W = 32
);
  logic             req0_valid;
  logic             req0_we;
  logic [ADR_W-1:0] req0_adr;
  logic [31:0]      req0_dat;
  logic [3:0]       req0_sel;
  logic             req0_done;
  logic [31:0]      req0_rdata;
  logic             req0_err;

  logic             req1_valid;
  logic             req1_we;
  logic [ADR_W-1:0] req1_adr;
  logic [31:0]      req1_dat;
  logic [3:0]       req1_sel;
  logic             req1_done;
  logic [31:0]      req1_rdata;
  logic             req1_err;

  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [ADR_W-1:0] wbm_adr_o;
  logic [31:0]      wbm_dat_o;
  logic             wbm_ack_i;
  logic [31:0]      wbm_dat_i;
  logic             busy;

  // Arbiter view: it is the Wishbone master and serves both requesters.
  modport master (
    input  req0_valid, req0_we, req0_adr, req0_dat, req0_sel,
    input  req1_valid, req1_we, req1_adr, req1_dat, req1_sel,
    input  wbm_ack_i, wbm_dat_i,
    output req0_done, req0_rdata, req0_err,
    output req1_done, req1_rdata, req1_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output busy
  );

  // Environment view: requesters plus the Wishbone slave.
  modport slave (
    output req0_valid, req0_we, req0_adr, req0_dat, req0_sel,
    output req1_valid, req1_we, req1_adr, req1_dat, req1_sel,
    output wbm_ack_i, wbm_dat_i,
    input  req0_done, req0_rdata, req0_err,
    input  req1_done, req1_rdata, req1_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/wb_host_arbiter.sv
`default_nettype none
// ============================================================================
// wb_host_arbiter : round-robin two-requester Wishbone classic master.
//                   Optional bus timeout abort: define WB_HOST_ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module wb_host_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADR_W          = 32
) (
  input wire                 wb_clk_i,
  input wire                 wb_rst_i,
  wb_host_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_host_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start;
  logic             w_gnt_sel;
  logic             w_ack;
  logic             w_expire;
  logic             w_finish;
  logic [31:0]      w_rdata_cap;
  logic             r_gnt;
  logic             r_last;
  logic             r_we;
  logic [3:0]       r_sel;
  logic [ADR_W-1:0] r_adr;
  logic [31:0]      r_dat;
  logic [31:0]      r_rdata0;
  logic [31:0]      r_rdata1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_gnt_sel   = r_gnt;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          w_start     = 1'b1;
          // On a tie the requester that did not win last time is served.
          w_gnt_sel   = (bus.req0_valid && bus.req1_valid) ? ~r_last : bus.req1_valid;
          w_state_nxt = S_BUS;
        end
      end
      S_BUS: begin
        if (bus.wbm_ack_i) begin
          w_ack       = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_expire) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_finish    = w_ack || w_expire;
  assign w_rdata_cap = w_ack ? bus.wbm_dat_i : 32'h0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_sel    <= 4'h0;
      r_adr    <= '0;
      r_dat    <= 32'h0;
      r_rdata0 <= 32'h0;
      r_rdata1 <= 32'h0;
    end else begin
      if (w_start) begin
        r_gnt  <= w_gnt_sel;
        r_last <= w_gnt_sel;
        r_we   <= w_gnt_sel ? bus.req1_we  : bus.req0_we;
        r_sel  <= w_gnt_sel ? bus.req1_sel : bus.req0_sel;
        r_adr  <= w_gnt_sel ? bus.req1_adr : bus.req0_adr;
        r_dat  <= w_gnt_sel ? bus.req1_dat : bus.req0_dat;
      end
      if (w_finish) begin
        if (r_gnt) r_rdata1 <= w_rdata_cap;
        else       r_rdata0 <= w_rdata_cap;
      end
    end
  end

`ifdef WB_HOST_ARB_TIMEOUT_EN
  localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;
  logic        r_err0;
  logic        r_err1;

  // Ack in the expiry cycle takes priority, so expiry requires no ack.
  assign w_expire = (r_state == S_BUS) && !bus.wbm_ack_i && (r_cnt == c_to_last);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt  <= 16'h0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      if (w_start)
        r_cnt <= 16'h0;
      else if (r_state == S_BUS && !bus.wbm_ack_i)
        r_cnt <= r_cnt + 16'd1;
      if (w_finish) begin
        if (r_gnt) r_err1 <= ~w_ack;
        else       r_err0 <= ~w_ack;
      end
    end
  end

  assign bus.req0_err = r_err0;
  assign bus.req1_err = r_err1;
`else
  assign w_expire     = 1'b0;
  assign bus.req0_err = 1'b0;
  assign bus.req1_err = 1'b0;
`endif

  assign bus.wbm_cyc_o  = (r_state == S_BUS);
  assign bus.wbm_stb_o  = (r_state == S_BUS);
  assign bus.wbm_we_o   = r_we;
  assign bus.wbm_sel_o  = r_sel;
  assign bus.wbm_adr_o  = r_adr;
  assign bus.wbm_dat_o  = r_dat;
  assign bus.req0_done  = (r_state == S_RESP) && !r_gnt;
  assign bus.req1_done  = (r_state == S_RESP) &&  r_gnt;
  assign bus.req0_rdata = r_rdata0;
  assign bus.req1_rdata = r_rdata1;
  assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/wb_host_arbiter.md
Name: wb_host_arbiter

Overview:
- Two-requester Wishbone classic master that shares the single Wishbone slave port of user_project_wrapper.
- Typical requesters: a bench/LA-driven command source and a scripted stimulus engine.
- Latches one request at a time, drives cyc/stb, waits for ack, then returns read data and a one-cycle completion pulse to the winning requester.
- Arbitration is round-robin; an optional bus-timeout abort is available.

Parameters:
- TIMEOUT_CYCLES, 255: BUS-state cycles without ack before abort. Used only with the timeout feature. Legal range 1..65535.
- ADR_W, 32: address width.

Ports:
- wb_clk_i  in  1  clock; all logic on posedge
- wb_rst_i  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 request; held until req0_done
- req0_we  in  1  1 = write, 0 = read
- req0_adr  in  ADR_W  byte address
- req0_dat  in  32  write data
- req0_sel  in  4  byte enables
- req0_done  out  1  one-cycle completion pulse
- req0_rdata  out  32  read data; valid while req0_done=1
- req0_err  out  1  timeout flag; valid while req0_done=1
- req1_*  same set as req0_*, for requester 1
- wbm_cyc_o, wbm_stb_o  out  1  Wishbone cycle/strobe (driven identically)
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  Wishbone byte select
- wbm_adr_o  out  ADR_W  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_ack_i  in  1  Wishbone acknowledge
- wbm_dat_i  in  32  Wishbone read data
- busy  out  1  high in BUS or RESP state

Behaviour:
- Reset (sync, wb_rst_i=1 at posedge):
  - state=IDLE, last_gnt=1 (requester 0 wins the first tie), timeout counter=0.
  - All outputs 0: cyc, stb, we, sel, adr, dat_o, done, rdata, err, busy.
  - Reset mid-transaction drops cyc/stb at that edge; no done pulse is issued for the aborted request.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Neither valid: stay IDLE.
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_gnt.
  - On grant: latch we/adr/dat/sel into wbm_* registers, set cyc=stb=1, record gnt and last_gnt, clear counter, go to BUS. cyc rises the cycle after valid is first sampled.
- BUS:
  - cyc/stb/we/adr/sel/dat_o held constant.
  - wbm_ack_i=1 sampled: capture wbm_dat_i into the granted rdata (writes capture it too; value is don't-care), err=0, cyc=stb=0, go to RESP.
  - wbm_ack_i sampled outside BUS is ignored.
- RESP:
  - Granted done=1 for exactly one cycle; the other requester's done stays 0.
  - Next edge: done=0, go to IDLE.
  - rdata/err hold until the next completion to that requester.
- Latency: valid high to done high = 2 + N cycles, where N = BUS cycles before ack (N=0 when ack is returned in the first BUS cycle). Minimum 2.
- Requester contract:
  - Hold valid and all fields stable until done is seen.
  - valid still high in the cycle after done is a new request.
  - No request is lost; a waiting requester is served at the next IDLE and wins any tie there.
- Changes to the non-granted requester's fields during BUS have no effect.
- Back-to-back: one IDLE cycle between transactions, so cyc drops for at least 2 cycles (RESP + IDLE).
- busy = (state != IDLE).

Optional Feature:
- Macro: WB_HOST_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit counter increments every BUS cycle without ack.
  - When counter == TIMEOUT_CYCLES-1 with no ack: cyc=stb=0, rdata=0, err=1, go to RESP (done pulse with err).
  - Ack in the same cycle as expiry wins: normal completion, err=0.
- Undefined: no counter; BUS waits indefinitely; err is tied to 0.

Test Plan:
- req0 write, adr=0x3000_0000, dat=0xDEAD_BEEF, sel=0xF, slave acks in the first BUS cycle -> wbm_cyc_o high 1 cycle with those values; req0_done pulses 2 cycles after valid; req1_done stays 0.
- req1 read, adr=0x3000_0004, slave acks after 3 wait cycles with 0x1234_5678 -> cyc high 4 cycles; req1_rdata=0x1234_5678 and req1_err=0 during the done pulse; latency 5.
- req0 and req1 both valid from reset, each kept high for 3 transactions -> grant order 0,1,0,1,0,1; cyc low at least 2 cycles between grants.
- WB_HOST_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> cyc high exactly 8 cycles, then req0_done=1, req0_err=1, req0_rdata=0; the next request completes normally with err=0.
- wb_rst_i pulsed during BUS with ack pending -> next cycle all outputs 0, no done; after release, the same request re-issues and completes.
- sel=0x5, we=0 with ack on the same cycle as a new req1_valid -> wbm_sel_o=0x5, req0_done, then req1 granted after one IDLE cycle.
